// File: rtl/bandgap_seq_ctrl.sv
// bandgap_seq_ctrl: power-up / check / retry sequencer for the standard and
// DTMOS bandgap cores plus the unity-gain buffer that drives the shared pin.
// Channel switches are break-before-make, either manual (ch_req) or
// auto-alternating every DWELL_CYCLES.
// Optional feature: define BGSEQ_KICK_EN to drive an 8-cycle start-up kick
// pulse at every STARTUP entry; otherwise kick is tied low.
module bandgap_seq_ctrl #(
  parameter int CNT_W          = 17,
  parameter int STARTUP_CYCLES = 4096,
  parameter int SETTLE_CYCLES  = 1024,
  parameter int BREAK_CYCLES   = 4,
  parameter int DWELL_CYCLES   = 65536,
  parameter int MAX_RETRY      = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       mode_auto,
  input  logic       ch_req,
  input  logic       ok_in,
  output logic [1:0] bg_en,
  output logic       buf_en,
  output logic       mux_sel,
  output logic       mux_break,
  output logic       ready,
  output logic       fault,
  output logic [2:0] state_o,
  output logic       kick
);

  typedef enum logic [2:0] {
    ST_OFF     = 3'd0,
    ST_STARTUP = 3'd1,
    ST_CHECK   = 3'd2,
    ST_SETTLE  = 3'd3,
    ST_READY   = 3'd4,
    ST_BREAK   = 3'd5,
    ST_FAULT   = 3'd6
  } state_t;

  localparam int RET_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  localparam logic [CNT_W-1:0] STARTUP_LAST = CNT_W'(STARTUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] BREAK_LAST   = CNT_W'(BREAK_CYCLES - 1);
  localparam logic [CNT_W-1:0] DWELL_LAST   = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [RET_W-1:0] RETRY_MAX    = RET_W'(MAX_RETRY);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   dwell;
  logic [RET_W-1:0]   retries;
  logic               sel_q;
  logic               target;
  logic               ok_meta, ok_sync;
  logic               tgt_eff;
  logic               timed;
  logic               retry_inc;

  // Two-flop synchroniser for the asynchronous comparator flag
  always_ff @(posedge clk) begin
    if (rst) begin
      ok_meta <= 1'b0;
      ok_sync <= 1'b0;
    end else begin
      ok_meta <= ok_in;
      ok_sync <= ok_meta;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_OFF;
    else     state <= state_nxt;
  end

  // Next-state and Moore output decode; en=0 overrides everything to OFF
  always_comb begin
    state_nxt = state;
    retry_inc = 1'b0;
    tgt_eff   = target;
    timed     = 1'b0;
    bg_en     = '0;
    buf_en    = 1'b0;
    mux_break = 1'b0;
    ready     = 1'b0;
    fault     = 1'b0;
    case (state)
      ST_OFF: state_nxt = ST_STARTUP;
      ST_STARTUP: begin
        bg_en = '1;
        timed = 1'b1;
        if (cnt == STARTUP_LAST) state_nxt = ST_CHECK;
      end
      ST_CHECK: begin
        bg_en = '1;
        if (ok_sync) state_nxt = ST_SETTLE;
        else if (retries < RETRY_MAX) begin
          retry_inc = 1'b1;
          state_nxt = ST_STARTUP;
        end else state_nxt = ST_FAULT;
      end
      ST_SETTLE: begin
        bg_en  = '1;
        buf_en = 1'b1;
        timed  = 1'b1;
        if (!ok_sync) state_nxt = ST_FAULT;
        else if (cnt == SETTLE_LAST) state_nxt = ST_READY;
      end
      ST_READY: begin
        bg_en  = '1;
        buf_en = 1'b1;
        ready  = 1'b1;
        if (mode_auto) tgt_eff = (dwell == DWELL_LAST) ? ~sel_q : sel_q;
        else           tgt_eff = ch_req;
        // Reference loss outranks a pending channel switch
        if (!ok_sync) state_nxt = ST_FAULT;
        else if (tgt_eff != sel_q) state_nxt = ST_BREAK;
      end
      ST_BREAK: begin
        bg_en     = '1;
        buf_en    = 1'b1;
        mux_break = 1'b1;
        timed     = 1'b1;
        if (!ok_sync) state_nxt = ST_FAULT;
        else if (cnt == BREAK_LAST) state_nxt = ST_SETTLE;
      end
      ST_FAULT: fault = 1'b1;
      default:  state_nxt = ST_OFF;
    endcase
    if (!en) begin
      state_nxt = ST_OFF;
      retry_inc = 1'b0;
    end
  end

  // Phase counter, dwell counter, retry count, target and mux select
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      dwell   <= '0;
      retries <= '0;
      sel_q   <= 1'b0;
      target  <= 1'b0;
    end else begin
      cnt <= (timed && (state_nxt == state)) ? cnt + 1'b1 : '0;
      // Dwell only runs in auto READY; leaving auto or READY restarts it
      dwell <= (state == ST_READY && state_nxt == ST_READY && mode_auto)
               ? dwell + 1'b1 : '0;
      if (!en || state == ST_OFF) retries <= '0;
      else if (retry_inc)         retries <= retries + 1'b1;
      if (state == ST_READY) target <= tgt_eff;
      // Select only moves on SETTLE entry (from CHECK or end of BREAK);
      // it is forced to 0 whenever the buffer path is inactive
      if (!(state_nxt inside {ST_SETTLE, ST_READY, ST_BREAK})) sel_q <= 1'b0;
      else if (state_nxt == ST_SETTLE && state != ST_SETTLE)   sel_q <= target;
    end
  end

  assign mux_sel = sel_q;
  assign state_o = state;

`ifdef BGSEQ_KICK_EN
  assign kick = (state == ST_STARTUP) && (cnt < CNT_W'(8));
`else
  assign kick = 1'b0;
`endif

endmodule
